// File: rtl/sr_pkg.sv
// Shared types and helpers for the serial shift chain (receiver and transmitter sides).
package sr_pkg;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_STOP} rx_state_t;

  // Bit-count register width for a frame of `size` data bits; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned size);
    return (size > 1) ? $clog2(size) : 1;
  endfunction

endpackage

// File: rtl/serial_to_parallel_rx_if.sv
// Parallel word output of the receiver: data plus valid/ready handshake.
interface serial_to_parallel_rx_if #(
  parameter int unsigned SIZE = 10
) ();

  logic [SIZE-1:0] par_out;
  logic            out_valid;
  logic            out_ready;

  modport master (output par_out, output out_valid, input  out_ready);
  modport slave  (input  par_out, input  out_valid, output out_ready);

endinterface

// File: rtl/serial_to_parallel_rx_dff_sr.sv
// Bank of D flops with synchronous active-high reset to a parameterised value.
module dff_sr #(
  parameter int unsigned   W       = 1,
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  always_ff @(posedge i_clk) begin
    if (i_rst) o_q <= RST_VAL;
    else       o_q <= i_d;
  end

endmodule

// File: rtl/serial_to_parallel_rx.sv
// Frames a 1-bit serial stream (start, SIZE data bits LSB first, stop) into parallel words
// with a single holding register, flagging bad stop bits and overruns.
module serial_to_parallel_rx
  import sr_pkg::*;
#(
  parameter int unsigned SIZE     = 10,
  parameter logic        IDLE_LVL = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           sin,
  serial_to_parallel_rx_if.master        bus,
  output logic                           frame_err,
  output logic                           overrun,
  output logic                           busy
);

  localparam int unsigned CNT_W = cnt_w(SIZE);

  localparam logic [1:0] ST_IDLE = 2'(S_IDLE);
  localparam logic [1:0] ST_DATA = 2'(S_DATA);
  localparam logic [1:0] ST_STOP = 2'(S_STOP);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SIZE - 1);

  logic [1:0]       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
  logic [SIZE-1:0]  r_shift, w_shift_nxt;
  logic [SIZE-1:0]  r_hold,  w_hold_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_ferr,  w_ferr_nxt;
  logic             r_ovr,   w_ovr_nxt;
  logic             r_busy,  w_busy_nxt;

  logic             w_stop_ok;
  logic             w_stop_bad;
  logic             w_load;
  logic             w_drain;

  dff_sr #(.W(2),     .RST_VAL(ST_IDLE)) u_state (.i_clk(clk), .i_rst(rst), .i_d(w_state_nxt), .o_q(r_state));
  dff_sr #(.W(CNT_W), .RST_VAL('0))      u_cnt   (.i_clk(clk), .i_rst(rst), .i_d(w_cnt_nxt),   .o_q(r_cnt));
  dff_sr #(.W(SIZE),  .RST_VAL('0))      u_shift (.i_clk(clk), .i_rst(rst), .i_d(w_shift_nxt), .o_q(r_shift));
  dff_sr #(.W(SIZE),  .RST_VAL('0))      u_hold  (.i_clk(clk), .i_rst(rst), .i_d(w_hold_nxt),  .o_q(r_hold));
  dff_sr #(.W(1),     .RST_VAL(1'b0))    u_valid (.i_clk(clk), .i_rst(rst), .i_d(w_valid_nxt), .o_q(r_valid));
  dff_sr #(.W(1),     .RST_VAL(1'b0))    u_ferr  (.i_clk(clk), .i_rst(rst), .i_d(w_ferr_nxt),  .o_q(r_ferr));
  dff_sr #(.W(1),     .RST_VAL(1'b0))    u_ovr   (.i_clk(clk), .i_rst(rst), .i_d(w_ovr_nxt),   .o_q(r_ovr));
  dff_sr #(.W(1),     .RST_VAL(1'b0))    u_busy  (.i_clk(clk), .i_rst(rst), .i_d(w_busy_nxt),  .o_q(r_busy));

  // Stop-bit verdict and holding-register handshake.
  always_comb begin
    w_stop_ok  = (r_state == ST_STOP) && (sin == IDLE_LVL);
    w_stop_bad = (r_state == ST_STOP) && (sin != IDLE_LVL);
    w_drain    = r_valid && bus.out_ready;
    w_load     = w_stop_ok && (!r_valid || bus.out_ready);
  end

  // Next-state, counter and shift register.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    unique case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (sin == ~IDLE_LVL) w_state_nxt = ST_DATA;
      end
      ST_DATA: begin
        w_shift_nxt = {sin, r_shift[SIZE-1:1]};
        if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_STOP;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_STOP: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Holding register, valid tracking and one-cycle status pulses.
  always_comb begin
    w_hold_nxt  = r_hold;
    w_valid_nxt = r_valid;
    if (w_load) begin
      w_hold_nxt  = r_shift;
      w_valid_nxt = 1'b1;
    end else if (w_drain) begin
      w_valid_nxt = 1'b0;
    end
    w_ferr_nxt = w_stop_bad;
    w_ovr_nxt  = w_stop_ok && r_valid && !bus.out_ready;
    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  assign bus.par_out   = r_hold;
  assign bus.out_valid = r_valid;
  assign frame_err     = r_ferr;
  assign overrun       = r_ovr;
  assign busy          = r_busy;

endmodule

// File: tb/tb_serial_to_parallel_rx.sv
// Directed and randomized frames against a word-level model of the receiver's holding slot.
module tb_serial_to_parallel_rx;

  localparam int unsigned SIZE = 10;

  logic clk = 1'b0;
  logic rst;
  logic sin;
  logic frame_err;
  logic overrun;
  logic busy;

  serial_to_parallel_rx_if #(.SIZE(SIZE)) bus ();

  serial_to_parallel_rx #(.SIZE(SIZE), .IDLE_LVL(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .sin       (sin),
    .bus       (bus),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [SIZE-1:0] exp_word = '0;
  logic [SIZE-1:0] cur_word = '0;
  bit              exp_valid = 1'b0;
  bit              exp_ferr  = 1'b0;
  bit              exp_ovr   = 1'b0;
  bit              rand_rdy  = 1'b0;

  task automatic chk(input string tag, input logic [SIZE-1:0] obs, input logic [SIZE-1:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One clock: model the slot's reaction to this edge, then check every output after it.
  task automatic tick(input bit stop_edge, input bit exp_busy);
    bit good;
    bit hs;
    if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
    if (exp_valid && bus.out_ready && !rst) chk("handshake_word", bus.par_out, exp_word);
    good     = stop_edge && (sin == 1'b1);
    hs       = exp_valid && bus.out_ready;
    exp_ferr = stop_edge && (sin == 1'b0);
    exp_ovr  = good && exp_valid && !bus.out_ready;
    if (good && (!exp_valid || bus.out_ready)) begin
      exp_word  = cur_word;
      exp_valid = 1'b1;
    end else if (hs) begin
      exp_valid = 1'b0;
    end
    if (rst) begin
      exp_word  = '0;
      exp_valid = 1'b0;
      exp_ferr  = 1'b0;
      exp_ovr   = 1'b0;
      exp_busy  = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("par_out",   bus.par_out,            exp_word);
    chk("out_valid", SIZE'(bus.out_valid),   SIZE'(exp_valid));
    chk("frame_err", SIZE'(frame_err),       SIZE'(exp_ferr));
    chk("overrun",   SIZE'(overrun),         SIZE'(exp_ovr));
    chk("busy",      SIZE'(busy),            SIZE'(exp_busy));
  endtask

  task automatic send_frame(input logic [SIZE-1:0] w, input bit stop, input bit rdy_at_stop);
    logic saved;
    cur_word = w;
    sin = 1'b0;
    tick(1'b0, 1'b1);
    for (int i = 0; i < SIZE; i++) begin
      sin = w[i];
      tick(1'b0, 1'b1);
    end
    saved = bus.out_ready;
    if (rdy_at_stop) bus.out_ready = 1'b1;
    sin = stop;
    tick(1'b1, 1'b0);
    if (rdy_at_stop) bus.out_ready = saved;
  endtask

  task automatic idle(input int n);
    sin = 1'b1;
    repeat (n) tick(1'b0, 1'b0);
  endtask

  initial begin
    logic [SIZE-1:0] w;
    rst = 1'b1;
    sin = 1'b0;
    bus.out_ready = 1'b0;

    // Reset held with a toggling line.
    for (int i = 0; i < 3; i++) begin
      sin = 1'(i);
      tick(1'b0, 1'b0);
    end
    rst = 1'b0;
    idle(2);

    // Good frame drained immediately.
    bus.out_ready = 1'b1;
    send_frame(10'h2A5, 1'b1, 1'b0);
    chk("t2_word", bus.par_out, 10'h2A5);
    idle(2);

    // Bad stop bit, then recovery.
    send_frame(10'h3FF, 1'b0, 1'b0);
    chk("t3_ferr", SIZE'(frame_err), SIZE'(1'b1));
    idle(2);
    send_frame(10'h155, 1'b1, 1'b0);
    idle(2);

    // Back-to-back frames with a stalled consumer.
    bus.out_ready = 1'b0;
    send_frame(10'h001, 1'b1, 1'b0);
    send_frame(10'h002, 1'b1, 1'b0);
    chk("t4_ovr", SIZE'(overrun), SIZE'(1'b1));
    chk("t4_held", bus.par_out, 10'h001);
    bus.out_ready = 1'b1;
    idle(1);
    chk("t4_drained", SIZE'(bus.out_valid), SIZE'(1'b0));
    idle(1);

    // Load and drain in the same stop cycle.
    bus.out_ready = 1'b0;
    send_frame(10'h0F0, 1'b1, 1'b0);
    idle(1);
    send_frame(10'h00F, 1'b1, 1'b1);
    chk("t5_word", bus.par_out, 10'h00F);
    chk("t5_valid", SIZE'(bus.out_valid), SIZE'(1'b1));
    bus.out_ready = 1'b1;
    idle(2);

    // Randomized frames, stop bits, gaps and consumer readiness.
    rand_rdy = 1'b1;
    for (int f = 0; f < 30; f++) begin
      w = SIZE'($urandom);
      send_frame(w, ($urandom_range(0, 7) != 0), 1'b0);
      idle(int'($urandom_range(0, 2)));
    end
    rand_rdy = 1'b0;
    bus.out_ready = 1'b1;
    idle(3);

    // Reset in the middle of a frame.
    w = 10'h2B6;
    bus.out_ready = 1'b0;
    sin = 1'b0;
    tick(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      sin = w[i];
      tick(1'b0, 1'b1);
    end
    rst = 1'b1;
    sin = w[5];
    tick(1'b0, 1'b0);
    rst = 1'b0;
    idle(2);
    bus.out_ready = 1'b1;
    send_frame(10'h1C3, 1'b1, 1'b0);
    chk("t6_word", bus.par_out, 10'h1C3);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
